bus_rr_router_arbiter: RTL and testbench

//   Parametrised successor to the single-bus generator/arbiter. It arbitrates among drvrs

---
 rtl/bus_rr_router_arbiter_if.sv | 25 ++
 rtl/bus_rr_router_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_rr_router_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_router_arbiter_if.sv
// Bus bundle between the router/arbiter and its FIFO-backed agents.
// The slave modport is the router's view; master is the agents' view.
interface bus_rr_router_arbiter_if #(
  parameter int unsigned drvrs   = 4,
  parameter int unsigned pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         full;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic                     busy;
  logic                     err;

  modport master (
    output pndng, D_pop, full,
    input  pop, push, D_push, busy, err
  );

  modport slave (
    input  pndng, D_pop, full,
    output pop, push, D_push, busy, err
  );
endinterface

// File: rtl/bus_rr_router_arbiter.sv
// Packet router: grants one agent (round-robin or fixed priority), pops its packet and pushes it
// to the decoded destination or to all other agents on broadcast. Option macro: BUS_ARB_TIMEOUT_EN.
module bus_rr_router_arbiter #(
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_sz   = 16,
  parameter int unsigned     ID_W      = 8,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int unsigned     ARB_MODE  = 0,
  parameter int unsigned     TIMEOUT   = 16
) (
  input logic                    clk,
  input logic                    reset,
  bus_rr_router_arbiter_if.slave bus
);
  localparam int unsigned      GW  = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, POP, CHECK, PUSH} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      src_q, src_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [GW-1:0]      arb_grant, arb_idx;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [pckg_sz-1:0] dpush_q, dpush_d;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [drvrs-1:0]   push_q, push_d;
  logic               err_q, err_d;
  logic [ID_W-1:0]    dest;
  logic               dest_uni, dest_bc, blocked;
  logic [drvrs-1:0]   src_mask, mask;
`ifdef BUS_ARB_TIMEOUT_EN
  logic [31:0]        cnt_q, cnt_d;
`endif

  // Later assignments override earlier ones, so each loop walks from lowest to highest priority.
  always_comb begin
    arb_grant = '0;
    arb_idx   = '0;
    if (ARB_MODE == 1) begin
      for (int i = int'(drvrs) - 1; i >= 0; i--) begin
        arb_idx = GW'(i);
        if (bus.pndng[arb_idx]) arb_grant = arb_idx;
      end
    end else begin
      for (int k = int'(drvrs); k >= 1; k--) begin
        arb_idx = GW'((int'(rr_q) + k) % int'(drvrs));
        if (bus.pndng[arb_idx]) arb_grant = arb_idx;
      end
    end
  end

  always_comb begin
    dest     = pkt_q[pckg_sz-1 -: ID_W];
    dest_uni = (32'(dest) < drvrs);
    dest_bc  = (dest == broadcast);
    src_mask = ONE << src_q;
    mask     = '0;
    if (dest_uni)     mask = ONE << dest;
    else if (dest_bc) mask = ~src_mask;
    blocked  = |(mask & bus.full);
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rr_d    = rr_q;
    pkt_d   = pkt_q;
    dpush_d = dpush_q;
    pop_d   = '0;
    push_d  = '0;
    err_d   = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.pndng) begin
          src_d   = arb_grant;
          pop_d   = ONE << arb_grant;
          state_d = POP;
        end
      end
      POP: begin
        pkt_d   = pckg_sz'(bus.D_pop >> (32'(src_q) * pckg_sz));
        state_d = CHECK;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      CHECK: begin
        // Broadcast is all-or-nothing: any full target in the mask holds the whole packet.
        if (!dest_uni && !dest_bc) begin
          err_d   = 1'b1;
          rr_d    = src_q;
          state_d = IDLE;
        end else if (!blocked) begin
          push_d  = mask;
          dpush_d = pkt_q;
          state_d = PUSH;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q + 32'd1 >= TIMEOUT) begin
          err_d   = 1'b1;
          rr_d    = src_q;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
`endif
      end
      PUSH: begin
        rr_d    = src_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight packet silently; the pointer restart makes agent 0 first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      rr_q    <= GW'(drvrs - 1);
      pkt_q   <= '0;
      dpush_q <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      err_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      dpush_q <= dpush_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      err_q   <= err_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.D_push = dpush_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_bus_rr_router_arbiter.sv
// Testbench for bus_rr_router_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level routing model.
module tb_bus_rr_router_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  int           checks = 0;
  int           passed = 0;
  logic [W-1:0] fifo [N][$];
  logic [N-1:0] prev_full;

  bus_rr_router_arbiter_if #(.drvrs(N), .pckg_sz(W)) bus ();
  bus_rr_router_arbiter_if #(.drvrs(N), .pckg_sz(W)) bus_fp ();

  bus_rr_router_arbiter #(.drvrs(N), .pckg_sz(W), .ID_W(8), .broadcast(8'hFF),
                          .ARB_MODE(0), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  bus_rr_router_arbiter #(.drvrs(N), .pckg_sz(W), .ID_W(8), .broadcast(8'hFF),
                          .ARB_MODE(1), .TIMEOUT(4)) dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp));

  always #5 clk = ~clk;

  // Agent FIFOs present their head word; idle slices carry junk the router must ignore.
  task automatic drive_agents();
    for (int i = 0; i < N; i++) begin
      bus.pndng[i]       = (fifo[i].size() > 0);
      bus.D_pop[i*W +: W] = (fifo[i].size() > 0) ? fifo[i][0] : W'($urandom);
    end
  endtask

  task automatic tick();
    logic [N-1:0] seen_pop;
    seen_pop  = bus.pop;
    prev_full = bus.full;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (seen_pop[i] === 1'b1 && fifo[i].size() > 0) void'(fifo[i].pop_front());
    drive_agents();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) fifo[i].delete();
    bus.full     = '0;
    bus_fp.full  = '0;
    bus_fp.pndng = '0;
    reset        = 1'b1;
    drive_agents();
    tick();
    tick();
    reset        = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) fifo[i].push_back({8'((i + 1) % N), 8'(8'hA0 + i)});
    reset = 1'b1;
    drive_agents();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({bus.pop, bus.push, bus.err, bus.busy} !== 10'b0)
        $display("[TB] FAIL reset_hold: pop/push/err/busy=%b required 0", {bus.pop, bus.push, bus.err, bus.busy});
      else passed++;
    end
    checks++;
    if (bus.D_push !== 16'h0) $display("[TB] FAIL reset_dpush: got %h required 0000", bus.D_push);
    else passed++;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.pop !== 4'b0001) $display("[TB] FAIL reset_first_grant: got %b required 0001", bus.pop);
    else passed++;
    checks++;
    if (bus.busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b required 1", bus.busy);
    else passed++;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.push, bus.err, bus.busy} !== 6'b0)
      $display("[TB] FAIL reset_midflight: push/err/busy=%b required 0", {bus.push, bus.err, bus.busy});
    else passed++;
  endtask

  task automatic test_unicast();
    fifo[1].push_back(16'h02AB);
    drive_agents();
    tick();
    checks++;
    if (bus.pop !== 4'b0010) $display("[TB] FAIL uni_pop: got %b required 0010", bus.pop);
    else passed++;
    tick();
    checks++;
    if ({bus.pop, bus.push} !== 8'b0) $display("[TB] FAIL uni_gap: pop/push=%b required 0", {bus.pop, bus.push});
    else passed++;
    tick();
    checks++;
    if (bus.push !== 4'b0100) $display("[TB] FAIL uni_push: got %b required 0100", bus.push);
    else passed++;
    checks++;
    if (bus.D_push !== 16'h02AB) $display("[TB] FAIL uni_data: got %h required 02ab", bus.D_push);
    else passed++;
    tick();
    checks++;
    if ({bus.push, bus.busy} !== 5'b0) $display("[TB] FAIL uni_end: push/busy=%b required 0", {bus.push, bus.busy});
    else passed++;
    checks++;
    if (bus.D_push !== 16'h02AB) $display("[TB] FAIL uni_hold: got %h required 02ab", bus.D_push);
    else passed++;
  endtask

  task automatic test_broadcast();
    fifo[0].push_back(16'hFF55);
    drive_agents();
    tick();
    checks++;
    if (bus.pop !== 4'b0001) $display("[TB] FAIL bc_pop: got %b required 0001", bus.pop);
    else passed++;
    tick();
    tick();
    checks++;
    if (bus.push !== 4'b1110) $display("[TB] FAIL bc_push: got %b required 1110", bus.push);
    else passed++;
    checks++;
    if (bus.D_push !== 16'hFF55) $display("[TB] FAIL bc_data: got %h required ff55", bus.D_push);
    else passed++;
    tick();
    checks++;
    if (bus.push !== 4'b0000) $display("[TB] FAIL bc_single: got %b required 0000", bus.push);
    else passed++;
  endtask

  task automatic test_round_robin();
    int           exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] got [$];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) fifo[i].push_back({8'((i + 2) % N), 8'(16 * i + j)});
    drive_agents();
    for (int c = 0; c < 17; c++) begin
      tick();
      if (bus.pop !== '0) got.push_back(bus.pop);
    end
    checks++;
    if (got.size() !== 5) $display("[TB] FAIL rr_count: got %0d pops required 5", got.size());
    else passed++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== N'(1 << exp_order[k]))
        $display("[TB] FAIL rr_order[%0d]: got %b required agent %0d", k, (k < got.size()) ? got[k] : 4'b0, exp_order[k]);
      else passed++;
    end
  endtask

  task automatic test_fixed_priority();
    int npop = 0;
    bus_fp.full  = '0;
    bus_fp.D_pop = {16'h0344, 16'h0233, 16'h0122, 16'h0311};
    bus_fp.pndng = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus_fp.pop !== '0) begin
        npop++;
        checks++;
        if (bus_fp.pop !== 4'b0001) $display("[TB] FAIL fp_pop: got %b required 0001", bus_fp.pop);
        else passed++;
      end
      if (c == 3) begin
        checks++;
        if (bus_fp.push !== 4'b1000) $display("[TB] FAIL fp_push: got %b required 1000", bus_fp.push);
        else passed++;
      end
    end
    checks++;
    if (npop !== 3) $display("[TB] FAIL fp_count: got %0d pops required 3", npop);
    else passed++;
  endtask

  task automatic test_back_pressure();
    int errs = 0;
    int pushes = 0;
    int exp_errs;
`ifdef BUS_ARB_TIMEOUT_EN
    exp_errs = 1;
`else
    exp_errs = 0;
`endif
    fifo[3].push_back(16'h0211);
    bus.full = 4'b0100;
    drive_agents();
    tick();
    checks++;
    if (bus.pop !== 4'b1000) $display("[TB] FAIL bp_pop: got %b required 1000", bus.pop);
    else passed++;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.err === 1'b1) errs++;
      if (bus.push !== '0) pushes++;
    end
    bus.full = '0;
    tick();
    if (bus.err === 1'b1) errs++;
    checks++;
    if (pushes !== 0) $display("[TB] FAIL bp_blocked: got %0d pushes while full, required 0", pushes);
    else passed++;
    checks++;
    if (errs !== exp_errs) $display("[TB] FAIL bp_err: got %0d err pulses required %0d", errs, exp_errs);
    else passed++;
    checks++;
    if (bus.push !== ((exp_errs == 0) ? 4'b0100 : 4'b0000))
      $display("[TB] FAIL bp_release: got %b required %b", bus.push, (exp_errs == 0) ? 4'b0100 : 4'b0000);
    else passed++;
    if (exp_errs == 0) begin
      checks++;
      if (bus.D_push !== 16'h0211) $display("[TB] FAIL bp_data: got %h required 0211", bus.D_push);
      else passed++;
    end
  endtask

  task automatic test_invalid_dest();
    fifo[2].push_back(16'h07C3);
    drive_agents();
    tick();
    checks++;
    if (bus.pop !== 4'b0100) $display("[TB] FAIL inv_pop: got %b required 0100", bus.pop);
    else passed++;
    tick();
    checks++;
    if (bus.err !== 1'b0) $display("[TB] FAIL inv_early_err: got %b required 0", bus.err);
    else passed++;
    tick();
    checks++;
    if ({bus.err, bus.push, bus.busy} !== 6'b100000)
      $display("[TB] FAIL inv_drop: err/push/busy=%b required 100000", {bus.err, bus.push, bus.busy});
    else passed++;
    tick();
    checks++;
    if ({bus.err, bus.push} !== 5'b0) $display("[TB] FAIL inv_pulse: err/push=%b required 0", {bus.err, bus.push});
    else passed++;
  endtask

  // Model: walk the preloaded queues in arbitration order and predict each pop and its outcome.
  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      logic [W-1:0] mq [N][$];
      int           exp_pop [$];
      logic [N-1:0] exp_mask [$];
      logic         exp_err [$];
      logic [W-1:0] exp_pkt [$];
      int           total, ptr, w, budget, sel;
      logic [7:0]   dest;
      logic [W-1:0] pkt;
      logic [N-1:0] em;
      logic         ee;
      logic [W-1:0] ep;
      do_reset();
      exp_pop.delete(); exp_mask.delete(); exp_err.delete(); exp_pkt.delete();
      total = 0;
      for (int i = 0; i < N; i++) begin
        int n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) begin
          sel  = $urandom_range(0, 9);
          dest = (sel < 6) ? 8'($urandom_range(0, N - 1)) : (sel < 8) ? 8'hFF : 8'($urandom_range(N, 254));
          fifo[i].push_back({dest, 8'($urandom)});
        end
        mq[i] = fifo[i];
        total += n;
      end
      ptr = N - 1;
      for (int t = 0; t < total; t++) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && mq[(ptr + k) % N].size() > 0) w = (ptr + k) % N;
        pkt  = mq[w].pop_front();
        dest = pkt[15:8];
        exp_pop.push_back(w);
        exp_pkt.push_back(pkt);
        if (int'(dest) < N) begin
          exp_mask.push_back(N'(1 << dest)); exp_err.push_back(1'b0);
        end else if (dest == 8'hFF) begin
          exp_mask.push_back(~N'(1 << w)); exp_err.push_back(1'b0);
        end else begin
          exp_mask.push_back('0); exp_err.push_back(1'b1);
        end
        ptr = w;
      end
      drive_agents();
      budget = 0;
      while ((exp_pop.size() > 0 || exp_err.size() > 0 || bus.busy !== 1'b0) && budget < 2000) begin
`ifndef BUS_ARB_TIMEOUT_EN
        bus.full = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
`endif
        tick();
        budget++;
        if (bus.pop !== '0) begin
          em = (exp_pop.size() > 0) ? N'(1 << exp_pop[0]) : '0;
          checks++;
          if (bus.pop !== em) $display("[TB] FAIL rnd_pop: got %b required %b", bus.pop, em);
          else passed++;
          if (exp_pop.size() > 0) void'(exp_pop.pop_front());
        end
        if (bus.push !== '0 || bus.err !== 1'b0) begin
          em = (exp_mask.size() > 0) ? exp_mask[0] : '0;
          ee = (exp_err.size() > 0) ? exp_err[0] : 1'b0;
          ep = (exp_pkt.size() > 0) ? exp_pkt[0] : '0;
          checks++;
          if ({bus.err, bus.push} !== {ee, em})
            $display("[TB] FAIL rnd_route: err/push=%b required %b (pkt %h)", {bus.err, bus.push}, {ee, em}, ep);
          else passed++;
          if (bus.push !== '0) begin
            checks++;
            if (bus.D_push !== ep) $display("[TB] FAIL rnd_data: got %h required %h", bus.D_push, ep);
            else passed++;
            checks++;
            if ((bus.push & prev_full) !== '0)
              $display("[TB] FAIL rnd_full: push %b into full %b, required no overlap", bus.push, prev_full);
            else passed++;
          end
          if (exp_mask.size() > 0) begin
            void'(exp_mask.pop_front()); void'(exp_err.pop_front()); void'(exp_pkt.pop_front());
          end
        end
      end
      bus.full = '0;
      checks++;
      if (budget >= 2000 || exp_pop.size() > 0 || exp_err.size() > 0)
        $display("[TB] FAIL rnd_drain: %0d pops and %0d routes outstanding after %0d cycles, required 0",
                 exp_pop.size(), exp_err.size(), budget);
      else passed++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    prev_full    = '0;
    bus.full     = '0;
    bus.pndng    = '0;
    bus.D_pop    = '0;
    bus_fp.full  = '0;
    bus_fp.pndng = '0;
    bus_fp.D_pop = '0;
    test_reset();
    do_reset();
    test_unicast();
    do_reset();
    test_broadcast();
    do_reset();
    test_round_robin();
    do_reset();
    test_fixed_priority();
    do_reset();
    test_back_pressure();
    do_reset();
    test_invalid_dest();
    test_random(6);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
